sbox_port_scheduler: RTL and testbench

SBOX_PORT_SCHEDULER -- requirements
Module: sbox_port_scheduler

---
 rtl/sbox_port_scheduler_pkg.sv | 25 ++
 rtl/sbox_port_scheduler_bram_lat_tracker.sv | 59 +++++
 rtl/sbox_port_scheduler.sv | 124 ++++++++++++
 tb/tb_sbox_port_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_port_scheduler_pkg.sv
// sbox_port_scheduler_pkg
// Shared constants and types for the S-box port scheduler: lookup geometry,
// the RAM read latency, the issue FSM state encoding and the latency-tracker
// tag format.
package sbox_port_scheduler_pkg;

  localparam int N_LOOKUP = 4;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 8;
  localparam int BRAM_LAT = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_LO = 2'd1,
    ISSUE_HI = 2'd2
  } issue_state_e;

  // One entry per issued address pair: valid marks a real issue, hi says the
  // pair carried bytes 2/3 rather than bytes 0/1.
  typedef struct packed {
    logic valid;
    logic hi;
  } tag_t;

endpackage

// File: rtl/sbox_port_scheduler_bram_lat_tracker.sv
// bram_lat_tracker
// Follows each issued address pair through the RAM read latency and
// assembles the four lookup bytes into one result word.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   stall         freezes the tag pipe and staging bytes (RAM is disabled too)
//   issue         an address pair is on the RAM ports this cycle
//   issue_hi      that pair is bytes 2/3 (otherwise bytes 0/1)
//   doa, dob      RAM port A/B read data
//   load          the assembled result is complete this cycle
//   result        {dob, doa, staged byte 1, staged byte 0}
module bram_lat_tracker
  import sbox_port_scheduler_pkg::*;
#(
  parameter int LAT = BRAM_LAT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         issue,
  input  logic                         issue_hi,
  input  logic [DATA_W-1:0]            doa,
  input  logic [DATA_W-1:0]            dob,
  output logic                         load,
  output logic [N_LOOKUP*DATA_W-1:0]   result
);

  tag_t              pipe [LAT];
  logic [DATA_W-1:0] staged0;
  logic [DATA_W-1:0] staged1;

  // Tag pipe advances only on cycles the RAM is enabled, so the tag leaving
  // the last stage always lines up with the data on doa/dob. A lo tag parks
  // bytes 0/1 until the matching hi pair arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe[i] <= '0;
      end
      staged0 <= '0;
      staged1 <= '0;
    end else if (!stall) begin
      pipe[0].valid <= issue;
      pipe[0].hi    <= issue_hi;
      for (int i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
      if (pipe[LAT-1].valid && !pipe[LAT-1].hi) begin
        staged0 <= doa;
        staged1 <= dob;
      end
    end
  end

  assign load   = ~stall & pipe[LAT-1].valid & pipe[LAT-1].hi;
  assign result = {dob, doa, staged1, staged0};

endmodule

// File: rtl/sbox_port_scheduler.sv
// sbox_port_scheduler
// Accepts four 10-bit S-box addresses per request and issues them to a
// dual-port RAM (output register enabled, 2-cycle latency) as two pairs,
// then returns the four 8-bit results as one word. One request per two
// cycles; a stalled output freezes the whole datapath including the RAM.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_addr request handshake, byte k = in_addr[10k+9:10k]
//   out_valid/out_ready/out_data result handshake, byte k = out_data[8k+7:8k]
//   bram_addra/bram_addrb     RAM port A/B addresses
//   bram_en                   RAM ENA/ENB/REGCEA/REGCEB
//   bram_doa/bram_dob         RAM port A/B read data
module sbox_port_scheduler #(
  parameter int BRAM_LAT = sbox_port_scheduler_pkg::BRAM_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [39:0] in_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [9:0]  bram_addra,
  output logic [9:0]  bram_addrb,
  output logic        bram_en,
  input  logic [7:0]  bram_doa,
  input  logic [7:0]  bram_dob
);

  import sbox_port_scheduler_pkg::*;

  issue_state_e                     state;
  logic [N_LOOKUP*ADDR_W-1:0]       req;
  logic                             started;
  logic                             stall;
  logic                             accept;
  logic                             load;
  logic [N_LOOKUP*DATA_W-1:0]       result;

  // A held result blocks everything upstream; the RAM is disabled as well so
  // its internal pipeline stays aligned with the tag pipe.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = started & ~stall & (state != ISSUE_LO);
  assign accept   = in_valid & in_ready;
  assign bram_en  = started & ~stall;

  // Keeps in_ready and bram_en low until the first clock edge after reset
  // is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started <= 1'b0;
    end else begin
      started <= 1'b1;
    end
  end

  // Issue FSM. Addresses are registered alongside the state so the RAM sees
  // the pair for the phase being entered; ISSUE_HI can chain straight into
  // the next request's ISSUE_LO to sustain one request per two cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req        <= '0;
      bram_addra <= '0;
      bram_addrb <= '0;
    end else if (!stall) begin
      case (state)
        IDLE, ISSUE_HI: begin
          if (accept) begin
            state      <= ISSUE_LO;
            req        <= in_addr;
            bram_addra <= in_addr[ADDR_W-1:0];
            bram_addrb <= in_addr[2*ADDR_W-1:ADDR_W];
          end else begin
            state      <= IDLE;
            bram_addra <= '0;
            bram_addrb <= '0;
          end
        end
        ISSUE_LO: begin
          state      <= ISSUE_HI;
          bram_addra <= req[3*ADDR_W-1:2*ADDR_W];
          bram_addrb <= req[4*ADDR_W-1:3*ADDR_W];
        end
        default: begin
          state      <= IDLE;
          bram_addra <= '0;
          bram_addrb <= '0;
        end
      endcase
    end
  end

  bram_lat_tracker #(
    .LAT(BRAM_LAT)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .issue    (state != IDLE),
    .issue_hi (state == ISSUE_HI),
    .doa      (bram_doa),
    .dob      (bram_dob),
    .load     (load),
    .result   (result)
  );

  // Output register. A new result takes priority over clearing, so a
  // handshake coinciding with a load keeps out_valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= result;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sbox_port_scheduler.sv
module tb_sbox_port_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [9:0]  bram_addra;
  logic [9:0]  bram_addrb;
  logic        bram_en;
  logic [7:0]  bram_doa = '0;
  logic [7:0]  bram_dob = '0;

  int checks = 0;
  int errors = 0;

  logic [39:0] b2bVec [8];
  logic [39:0] bpVec  [8];

  sbox_port_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .bram_addra (bram_addra),
    .bram_addrb (bram_addrb),
    .bram_en    (bram_en),
    .bram_doa   (bram_doa),
    .bram_dob   (bram_dob)
  );

  always #5 clk = ~clk;

  // Golden S-box table contents, shared by the RAM model and the expectations
  function automatic logic [7:0] sbox(input logic [9:0] a);
    logic [9:0] t;
    t = a ^ (a >> 3);
    t = t * 10'd7 + 10'h1B;
    return t[7:0];
  endfunction

  function automatic logic [31:0] expResult(input logic [39:0] a);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = sbox(a[10*k +: 10]);
    end
    return r;
  endfunction

  // Dual-port RAM with address latch plus enabled output register
  logic [9:0] ramAddrA = '0;
  logic [9:0] ramAddrB = '0;
  always @(posedge clk) begin
    if (bram_en) begin
      ramAddrA <= bram_addra;
      ramAddrB <= bram_addrb;
      bram_doa <= sbox(ramAddrA);
      bram_dob <= sbox(ramAddrB);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [39:0] a, input logic r);
    in_valid  = v;
    in_addr   = a;
    out_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkOutput(tag, 64'(obs), 64'(exp));
  endtask

  // One isolated request from IDLE: phase addresses, IDLE zeroing, latency, data
  task automatic singleRequest(input string tag, input logic [39:0] a);
    applyStimulus(1'b1, a, 1'b1);
    #1;
    checkBit({tag, "_ready_idle"}, in_ready, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    #1;
    checkBit({tag, "_ready_lo"}, in_ready, 1'b0);
    checkOutput({tag, "_addra_lo"}, 64'(bram_addra), 64'(a[9:0]));
    checkOutput({tag, "_addrb_lo"}, 64'(bram_addrb), 64'(a[19:10]));
    tick();
    #1;
    checkBit({tag, "_ready_hi"}, in_ready, 1'b1);
    checkOutput({tag, "_addra_hi"}, 64'(bram_addra), 64'(a[29:20]));
    checkOutput({tag, "_addrb_hi"}, 64'(bram_addrb), 64'(a[39:30]));
    tick();
    #1;
    checkOutput({tag, "_addra_idle"}, 64'(bram_addra), 64'd0);
    checkOutput({tag, "_addrb_idle"}, 64'(bram_addrb), 64'd0);
    checkBit({tag, "_valid_k3"}, out_valid, 1'b0);
    tick();
    #1;
    checkBit({tag, "_valid_k4"}, out_valid, 1'b0);
    tick();
    #1;
    checkBit({tag, "_valid_k5"}, out_valid, 1'b1);
    checkOutput({tag, "_data"}, 64'(out_data), 64'(expResult(a)));
    tick();
    #1;
    checkBit({tag, "_valid_after"}, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      b2bVec[i] = {10'(i * 97 + 3), 10'(i * 31 + 700), 10'(i * 5 + 100), 10'(i * 113 + 1)};
      bpVec[i]  = {10'(i * 41 + 900), 10'(i * 13 + 7), 10'(i * 77 + 333), 10'(i * 59 + 512)};
    end

    // Reset state
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    #1;
    checkBit("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_addra", 64'(bram_addra), 64'd0);
    checkOutput("rst_addrb", 64'(bram_addrb), 64'd0);
    checkBit("rst_bram_en", bram_en, 1'b0);
    checkBit("rst_in_ready", in_ready, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkBit("rel_in_ready_early", in_ready, 1'b0);
    tick();
    #1;
    checkBit("rel_in_ready", in_ready, 1'b1);
    checkBit("rel_bram_en", bram_en, 1'b1);

    // Single request with mixed boundary bytes
    $display("[TB] single request");
    singleRequest("single", {10'h3FF, 10'h200, 10'h0FF, 10'h001});

    // Back-to-back streaming: accepts every 2 cycles, results every 2 cycles
    $display("[TB] back-to-back");
    for (int c = 0; c < 22; c++) begin
      if (c < 16) begin
        if (c % 2 == 0) applyStimulus(1'b1, b2bVec[c / 2], 1'b1);
      end else begin
        applyStimulus(1'b0, '0, 1'b1);
      end
      #1;
      if (c < 16) checkBit($sformatf("b2b_ready_c%0d", c), in_ready, (c % 2 == 0));
      if (c >= 5) begin
        if ((c - 5) % 2 == 0 && (c - 5) / 2 < 8) begin
          checkBit($sformatf("b2b_valid_c%0d", c), out_valid, 1'b1);
          checkOutput($sformatf("b2b_data%0d", (c - 5) / 2), 64'(out_data), 64'(expResult(b2bVec[(c - 5) / 2])));
        end else begin
          checkBit($sformatf("b2b_valid_c%0d", c), out_valid, 1'b0);
        end
      end
      tick();
    end

    // Backpressure during streaming: out_ready low for 6 cycles
    $display("[TB] backpressure");
    begin
      int nextIn;
      int nextOut;
      int stallSeen;
      logic prevStall;
      logic [31:0] prevData;
      nextIn = 0;
      nextOut = 0;
      stallSeen = 0;
      prevStall = 1'b0;
      prevData = '0;
      for (int c = 0; c < 80 && nextOut < 8; c++) begin
        applyStimulus(nextIn < 8, (nextIn < 8) ? bpVec[nextIn] : 40'd0, !(c >= 6 && c < 12));
        #1;
        if (prevStall) begin
          checkOutput("bp_hold_data", 64'(out_data), 64'(prevData));
          checkBit("bp_hold_valid", out_valid, 1'b1);
        end
        if (out_valid && !out_ready) begin
          stallSeen++;
          checkBit("bp_en_stalled", bram_en, 1'b0);
          checkBit("bp_ready_stalled", in_ready, 1'b0);
        end else begin
          checkBit("bp_en_running", bram_en, 1'b1);
        end
        if (out_valid && out_ready) begin
          checkOutput($sformatf("bp_result%0d", nextOut), 64'(out_data), 64'(expResult(bpVec[nextOut])));
          nextOut++;
        end
        if (in_valid && in_ready) nextIn++;
        prevStall = out_valid & ~out_ready;
        prevData = out_data;
        tick();
      end
      checkOutput("bp_all_results", 64'(nextOut), 64'd8);
      checkBit("bp_stall_seen", stallSeen > 0, 1'b1);
      applyStimulus(1'b0, '0, 1'b1);
      #1;
      checkBit("bp_no_duplicate", out_valid, 1'b0);
      tick();
      tick();
      #1;
      checkBit("bp_drained", out_valid, 1'b0);
    end

    // Reset in cycle k+3 while a second request is being issued
    $display("[TB] reset mid-flight");
    applyStimulus(1'b1, {10'h111, 10'h222, 10'h333, 10'h044}, 1'b1);
    tick();
    applyStimulus(1'b1, {10'h155, 10'h2AA, 10'h0F0, 10'h30F}, 1'b1);
    tick();
    tick();
    #1;
    checkOutput("mid_pre_addra", 64'(bram_addra), 64'h30F);
    rst = 1'b0;
    #1;
    checkBit("mid_out_valid", out_valid, 1'b0);
    checkOutput("mid_out_data", 64'(out_data), 64'd0);
    checkOutput("mid_addra", 64'(bram_addra), 64'd0);
    checkOutput("mid_addrb", 64'(bram_addrb), 64'd0);
    checkBit("mid_bram_en", bram_en, 1'b0);
    checkBit("mid_in_ready", in_ready, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    #1;
    checkBit("mid_hold_valid", out_valid, 1'b0);
    rst = 1'b1;
    #1;
    checkBit("mid_rel_ready_early", in_ready, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      #1;
      checkBit($sformatf("mid_no_ghost_c%0d", c), out_valid, 1'b0);
    end
    singleRequest("fresh", {10'h07E, 10'h381, 10'h155, 10'h2C3});

    // Address boundaries
    $display("[TB] boundaries");
    singleRequest("zeros", 40'd0);
    singleRequest("ones", {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
